cache_bus_arb: RTL and testbench

Two-master burst arbiter between the instruction-cache refill path (s0) and the data-cache refill/write-back path (s1), sharing one Avalon-MM burst master port (m0) to the system bus. Ownership is granted per whole burst: once a port wins, it keeps the bus until every read beat has returned or every write beat has been accepted. Sits between the cache top-level modules and the bus interconnect.

---
 rtl/cache_bus_arb.sv | 174 +++++++++++++++++
 tb/tb_cache_bus_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_bus_arb.sv
// Two-master whole-burst arbiter: I-cache refill (s0) and D-cache refill/write-back (s1) share one Avalon-MM burst master.
// Define CACHE_ARB_RR_EN for round-robin on contention; otherwise s1 wins simultaneous requests.
module cache_bus_arb (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] s0_address,
  input  logic [3:0]  s0_byteEnable,
  input  logic        s0_read,
  input  logic        s0_write,
  input  logic [31:0] s0_writeData,
  input  logic        s0_beginBurstTransfer,
  input  logic [7:0]  s0_burstCount,
  output logic        s0_waitRequest,
  output logic [31:0] s0_readData,
  output logic        s0_readDataValid,
  input  logic [31:0] s1_address,
  input  logic [3:0]  s1_byteEnable,
  input  logic        s1_read,
  input  logic        s1_write,
  input  logic [31:0] s1_writeData,
  input  logic        s1_beginBurstTransfer,
  input  logic [7:0]  s1_burstCount,
  output logic        s1_waitRequest,
  output logic [31:0] s1_readData,
  output logic        s1_readDataValid,
  output logic [31:0] m0_address,
  output logic [3:0]  m0_byteEnable,
  output logic        m0_read,
  output logic        m0_write,
  output logic [31:0] m0_writeData,
  output logic        m0_beginBurstTransfer,
  output logic [7:0]  m0_burstCount,
  input  logic        m0_waitRequest,
  input  logic [31:0] m0_readData,
  input  logic        m0_readDataValid,
  output logic [1:0]  grant
);

  // Handshake: a command beat transfers on a cycle where read/write is high and waitRequest is low.
  typedef enum logic [1:0] {IDLE, GNT, RD} state_e;

  state_e     state_q;
  logic [1:0] grant_q;
  logic [7:0] cnt_q;
  logic       wr_active_q;
`ifdef CACHE_ARB_RR_EN
  logic       last_q;
`endif

  logic        req0, req1, pick_s1;
  logic        own_s1;
  logic [31:0] own_address;
  logic [3:0]  own_byteEnable;
  logic        own_read;
  logic        own_write;
  logic [31:0] own_writeData;
  logic        own_begin;
  logic [7:0]  own_burstCount;

  assign req0 = s0_read | s0_write;
  assign req1 = s1_read | s1_write;

`ifdef CACHE_ARB_RR_EN
  // last_q = 1 means s1 won last, so s0 takes a tie.
  assign pick_s1 = req1 & (~req0 | ~last_q);
`else
  assign pick_s1 = req1;
`endif

  assign own_s1         = grant_q[1];
  assign own_address    = own_s1 ? s1_address            : s0_address;
  assign own_byteEnable = own_s1 ? s1_byteEnable         : s0_byteEnable;
  assign own_read       = own_s1 ? s1_read               : s0_read;
  assign own_write      = own_s1 ? s1_write              : s0_write;
  assign own_writeData  = own_s1 ? s1_writeData          : s0_writeData;
  assign own_begin      = own_s1 ? s1_beginBurstTransfer : s0_beginBurstTransfer;
  assign own_burstCount = own_s1 ? s1_burstCount         : s0_burstCount;

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q     <= IDLE;
      grant_q     <= 2'b00;
      cnt_q       <= 8'd0;
      wr_active_q <= 1'b0;
`ifdef CACHE_ARB_RR_EN
      last_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          wr_active_q <= 1'b0;
          if (req0 | req1) begin
            grant_q <= pick_s1 ? 2'b10 : 2'b01;
            state_q <= GNT;
`ifdef CACHE_ARB_RR_EN
            last_q  <= pick_s1;
`endif
          end
        end
        GNT: begin
          if (own_read) begin
            if (!m0_waitRequest) begin
              cnt_q   <= (own_burstCount == 8'd0) ? 8'd1 : own_burstCount;
              state_q <= RD;
            end
          end else if (own_write && !m0_waitRequest) begin
            if (!wr_active_q) begin
              // First beat: remaining beats after this one; 0 or 1 means single-beat burst.
              if (own_burstCount <= 8'd1) begin
                cnt_q   <= 8'd0;
                grant_q <= 2'b00;
                state_q <= IDLE;
              end else begin
                cnt_q       <= own_burstCount - 8'd1;
                wr_active_q <= 1'b1;
              end
            end else begin
              if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
              if (cnt_q <= 8'd1) begin
                grant_q     <= 2'b00;
                wr_active_q <= 1'b0;
                state_q     <= IDLE;
              end
            end
          end
        end
        RD: begin
          if (m0_readDataValid) begin
            if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
            if (cnt_q <= 8'd1) begin
              grant_q <= 2'b00;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          grant_q <= 2'b00;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    m0_address            = 32'd0;
    m0_byteEnable         = 4'd0;
    m0_read               = 1'b0;
    m0_write              = 1'b0;
    m0_writeData          = 32'd0;
    m0_beginBurstTransfer = 1'b0;
    m0_burstCount         = 8'd0;
    s0_waitRequest        = 1'b1;
    s1_waitRequest        = 1'b1;
    if (state_q == GNT) begin
      m0_address            = own_address;
      m0_byteEnable         = own_byteEnable;
      m0_read               = own_read;
      m0_write              = own_write & ~own_read;
      m0_writeData          = own_writeData;
      m0_beginBurstTransfer = own_begin;
      m0_burstCount         = own_burstCount;
      if (own_s1) s1_waitRequest = m0_waitRequest;
      else        s0_waitRequest = m0_waitRequest;
    end
  end

  // Read data is broadcast; only the valid strobe is steered to the owner.
  assign s0_readData      = m0_readData;
  assign s1_readData      = m0_readData;
  assign s0_readDataValid = m0_readDataValid & grant_q[0];
  assign s1_readDataValid = m0_readDataValid & grant_q[1];
  assign grant            = grant_q;

endmodule

// File: tb/tb_cache_bus_arb.sv
// Directed bench for cache_bus_arb: reads, stalled write burst, zero burst count, reset mid-read, contention.
module tb_cache_bus_arb;

  logic        clk = 1'b0;
  logic        rest;
  logic [31:0] s0_address, s1_address;
  logic [3:0]  s0_byteEnable, s1_byteEnable;
  logic        s0_read, s1_read, s0_write, s1_write;
  logic [31:0] s0_writeData, s1_writeData;
  logic        s0_beginBurstTransfer, s1_beginBurstTransfer;
  logic [7:0]  s0_burstCount, s1_burstCount;
  logic        s0_waitRequest, s1_waitRequest;
  logic [31:0] s0_readData, s1_readData;
  logic        s0_readDataValid, s1_readDataValid;
  logic [31:0] m0_address;
  logic [3:0]  m0_byteEnable;
  logic        m0_read, m0_write;
  logic [31:0] m0_writeData;
  logic        m0_beginBurstTransfer;
  logic [7:0]  m0_burstCount;
  logic        m0_waitRequest;
  logic [31:0] m0_readData;
  logic        m0_readDataValid;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_fail   = 0;
  int last_m   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] bus_q[$];

  cache_bus_arb dut (
    .clk(clk), .rest(rest),
    .s0_address(s0_address), .s0_byteEnable(s0_byteEnable), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writeData(s0_writeData), .s0_beginBurstTransfer(s0_beginBurstTransfer), .s0_burstCount(s0_burstCount),
    .s0_waitRequest(s0_waitRequest), .s0_readData(s0_readData), .s0_readDataValid(s0_readDataValid),
    .s1_address(s1_address), .s1_byteEnable(s1_byteEnable), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writeData(s1_writeData), .s1_beginBurstTransfer(s1_beginBurstTransfer), .s1_burstCount(s1_burstCount),
    .s1_waitRequest(s1_waitRequest), .s1_readData(s1_readData), .s1_readDataValid(s1_readDataValid),
    .m0_address(m0_address), .m0_byteEnable(m0_byteEnable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writeData(m0_writeData), .m0_beginBurstTransfer(m0_beginBurstTransfer), .m0_burstCount(m0_burstCount),
    .m0_waitRequest(m0_waitRequest), .m0_readData(m0_readData), .m0_readDataValid(m0_readDataValid),
    .grant(grant)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef CACHE_ARB_RR_EN
      return (last_m == 1) ? 0 : 1;
`else
      return 1;
`endif
    end
    return r1 ? 1 : 0;
  endfunction

  // Entered at posedge+1 in IDLE with port p's read request already driven.
  task automatic run_read(input int p);
    logic [7:0] bc;
    logic [1:0] g;
    int beats;
    logic [31:0] d;
    bc    = p ? s1_burstCount : s0_burstCount;
    beats = (bc == 8'd0) ? 1 : int'(bc);
    g     = p ? 2'b10 : 2'b01;
    #1;
    chk("rd_idle_grant", grant, 2'b00);
    @(posedge clk); #1;
    chk("rd_grant", grant, g);
    chk("rd_cmd", m0_read, 1);
    chk("rd_no_write", m0_write, 0);
    chk("rd_addr", m0_address, p ? s1_address : s0_address);
    chk("rd_bc", m0_burstCount, bc);
    chk("rd_other_wait", p ? s0_waitRequest : s1_waitRequest, 1);
    for (int i = 0; i < beats; i++) begin
      d = $urandom;
      bus_q.push_back(d);
      exp_q.push_back(d);
    end
    @(posedge clk); #1;
    if (p) begin s1_read = 0; s1_write = 0; s1_beginBurstTransfer = 0; end
    else   begin s0_read = 0; s0_write = 0; s0_beginBurstTransfer = 0; end
    #1;
    chk("rd_pend_wait0", s0_waitRequest, 1);
    chk("rd_pend_wait1", s1_waitRequest, 1);
    chk("rd_pend_cmd", m0_read, 0);
    for (int i = 0; i < beats; i++) begin
      m0_readDataValid = 1;
      m0_readData = bus_q.pop_front();
      #1;
      chk("rd_valid", p ? s1_readDataValid : s0_readDataValid, 1);
      chk("rd_other_valid", p ? s0_readDataValid : s1_readDataValid, 0);
      chk("rd_data", p ? s1_readData : s0_readData, exp_q.pop_front());
      @(posedge clk); #1;
      m0_readDataValid = 0;
      if (i == 0 && beats > 1) begin
        #1;
        chk("rd_gap_grant", grant, g);
        @(posedge clk); #1;
      end
    end
    #1;
    chk("rd_done_grant", grant, 2'b00);
  endtask

  initial begin
    logic [31:0] d;
    int w;
    rest = 1;
    s0_address = 0; s0_byteEnable = 0; s0_read = 0; s0_write = 0; s0_writeData = 0;
    s0_beginBurstTransfer = 0; s0_burstCount = 0;
    s1_address = 0; s1_byteEnable = 0; s1_read = 0; s1_write = 0; s1_writeData = 0;
    s1_beginBurstTransfer = 0; s1_burstCount = 0;
    m0_waitRequest = 0; m0_readData = 0; m0_readDataValid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 2'b00);
    chk("rst_wait0", s0_waitRequest, 1);
    chk("rst_wait1", s1_waitRequest, 1);
    chk("rst_m0_read", m0_read, 0);
    chk("rst_m0_addr", m0_address, 0);
    rest = 0;

    // Single read, s0, 4 beats
    @(posedge clk); #1;
    s0_address = 32'h0000_1000; s0_burstCount = 8'd4; s0_byteEnable = 4'hF;
    s0_read = 1; s0_beginBurstTransfer = 1;
    last_m = pick(1, 0);
    run_read(0);

    // burstCount = 0, read and write asserted together: read wins, one beat
    @(posedge clk); #1;
    s0_address = 32'h0000_1100; s0_burstCount = 8'd0;
    s0_read = 1; s0_write = 1; s0_beginBurstTransfer = 1;
    last_m = pick(1, 0);
    run_read(0);

    // s1 write burst of 8 with stalls on beats 3 and 6
    @(posedge clk); #1;
    s1_address = 32'h0000_2000; s1_burstCount = 8'd8; s1_byteEnable = 4'hF;
    s1_write = 1; s1_beginBurstTransfer = 1; s1_writeData = 32'h0;
    last_m = pick(0, 1);
    #1;
    chk("wr_idle_grant", grant, 2'b00);
    @(posedge clk); #1;
    chk("wr_grant", grant, 2'b10);
    chk("wr_addr", m0_address, 32'h0000_2000);
    chk("wr_bc", m0_burstCount, 8'd8);
    for (int k = 0; k < 8; k++) begin
      d = $urandom;
      s1_writeData = d;
      s1_beginBurstTransfer = (k == 0);
      exp_q.push_back(d);
      if (k == 2 || k == 5) begin
        m0_waitRequest = 1;
        #1;
        chk("wr_stall_wait1", s1_waitRequest, 1);
        chk("wr_stall_grant", grant, 2'b10);
        @(posedge clk); #1;
        m0_waitRequest = 0;
      end
      #1;
      chk("wr_wait0", s0_waitRequest, 1);
      chk("wr_wait1", s1_waitRequest, 0);
      chk("wr_cmd", m0_write, 1);
      chk("wr_begin", m0_beginBurstTransfer, (k == 0) ? 1 : 0);
      chk("wr_beat_grant", grant, 2'b10);
      chk("wr_data", m0_writeData, exp_q.pop_front());
      @(posedge clk); #1;
    end
    s1_write = 0; s1_beginBurstTransfer = 0;
    #1;
    chk("wr_done_grant", grant, 2'b00);
    chk("wr_done_cmd", m0_write, 0);

    // Reset in the middle of an 8-beat read
    @(posedge clk); #1;
    s0_address = 32'h0000_3000; s0_burstCount = 8'd8; s0_read = 1; s0_beginBurstTransfer = 1;
    @(posedge clk); #1;
    chk("rr_grant", grant, 2'b01);
    @(posedge clk); #1;
    s0_read = 0; s0_beginBurstTransfer = 0;
    for (int i = 0; i < 2; i++) begin
      d = $urandom;
      m0_readDataValid = 1; m0_readData = d;
      #1;
      chk("rr_valid", s0_readDataValid, 1);
      chk("rr_data", s0_readData, d);
      @(posedge clk); #1;
    end
    rest = 1;
    m0_readDataValid = 1;
    @(posedge clk); #1;
    chk("rr_rst_grant", grant, 2'b00);
    chk("rr_rst_wait0", s0_waitRequest, 1);
    chk("rr_rst_wait1", s1_waitRequest, 1);
    chk("rr_rst_read", m0_read, 0);
    chk("rr_rst_write", m0_write, 0);
    chk("rr_rst_begin", m0_beginBurstTransfer, 0);
    chk("rr_rst_addr", m0_address, 0);
    chk("rr_rst_be", m0_byteEnable, 0);
    chk("rr_rst_wdata", m0_writeData, 0);
    chk("rr_rst_bc", m0_burstCount, 0);
    chk("rr_rst_valid0", s0_readDataValid, 0);
    chk("rr_rst_valid1", s1_readDataValid, 0);
    rest = 0;
    m0_readDataValid = 0;
    last_m = 0;

    // Two rounds of simultaneous read requests
    for (int r = 0; r < 2; r++) begin
      @(posedge clk); #1;
      s0_address = 32'h0000_4000 + 32'(r); s0_burstCount = 8'd2; s0_read = 1; s0_beginBurstTransfer = 1;
      s1_address = 32'h0000_5000 + 32'(r); s1_burstCount = 8'd3; s1_read = 1; s1_beginBurstTransfer = 1;
      w = pick(1, 1);
      last_m = w;
      run_read(w);
      last_m = 1 - w;
      run_read(1 - w);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
